// File: rtl/legv8_ctrl_pkg.sv
// Shared definitions for the LEGv8 multicycle control path: opcode constants,
// ALUOp encodings, FSM state and instruction-class enumerations.
package legv8_ctrl_pkg;

   localparam int OPC_W = 11;
   localparam int ST_W  = 3;

   localparam logic [OPC_W-1:0] OPC_ADD  = 11'b10001011000;
   localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;
   localparam logic [OPC_W-1:0] OPC_AND  = 11'b10001010000;
   localparam logic [OPC_W-1:0] OPC_ORR  = 11'b10101010000;
   localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
   localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;

   // CBZ and B carry immediate bits inside IR[31:21]; only their prefixes identify them
   localparam logic [7:0] OPC_CBZ_PFX = 8'b10110100;
   localparam logic [5:0] OPC_B_PFX   = 6'b000101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_PASSB = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [ST_W-1:0] {
      S_RESET  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      C_ILLEGAL = 4'd0,
      C_ADD     = 4'd1,
      C_SUB     = 4'd2,
      C_AND     = 4'd3,
      C_ORR     = 4'd4,
      C_LDUR    = 4'd5,
      C_STUR    = 4'd6,
      C_CBZ     = 4'd7,
      C_B       = 4'd8
   } iclass_t;

   function automatic logic is_rtype(input iclass_t c);
      return (c == C_ADD) || (c == C_SUB) || (c == C_AND) || (c == C_ORR);
   endfunction

endpackage

// File: rtl/legv8_opcode_classifier.sv
// Combinational decode of IR[31:21] into an instruction class.
module legv8_opcode_classifier
   import legv8_ctrl_pkg::*;
(
   input  logic [OPC_W-1:0] opcode,
   output iclass_t          iclass
);

   localparam int N_EXACT = 6;

   localparam logic [OPC_W-1:0] EXACT_OPC [0:N_EXACT-1] =
      '{OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR, OPC_LDUR, OPC_STUR};
   localparam iclass_t EXACT_CLS [0:N_EXACT-1] =
      '{C_ADD, C_SUB, C_AND, C_ORR, C_LDUR, C_STUR};

   logic [N_EXACT-1:0] hit;
   logic               cbz_hit;
   logic               b_hit;

   genvar gi;
   generate
      for (gi = 0; gi < N_EXACT; gi++) begin : g_exact
         assign hit[gi] = (opcode == EXACT_OPC[gi]);
      end
   endgenerate

   assign cbz_hit = (opcode[10:3] == OPC_CBZ_PFX);
   assign b_hit   = (opcode[10:5] == OPC_B_PFX);

   // Exact patterns and prefixes are disjoint, so priority order is irrelevant
   always_comb begin
      iclass = C_ILLEGAL;
      for (int i = 0; i < N_EXACT; i++) begin
         if (hit[i]) begin
            iclass = EXACT_CLS[i];
         end
      end
      if (cbz_hit) begin
         iclass = C_CBZ;
      end
      if (b_hit) begin
         iclass = C_B;
      end
   end

endmodule

// File: rtl/legv8_multicycle_control.sv
// Multicycle main control FSM for the LEGv8 datapath: state register, latched
// instruction class and per-state strobe decode.
module legv8_multicycle_control
   import legv8_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OPC_W-1:0] opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic [1:0]       alu_op,
   output logic             alu_src,
   output logic             reg2loc,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             illegal,
   output logic [ST_W-1:0]  state_o
);

   state_t  state_reg;
   state_t  state_next;
   iclass_t class_reg;
   iclass_t dec_class;

   legv8_opcode_classifier u_classifier (
      .opcode (opcode),
      .iclass (dec_class)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_RESET;
         class_reg <= C_ILLEGAL;
      end else begin
         state_reg <= state_next;
         // Class is captured once; later opcode changes must not disturb the instruction
         if (state_reg == S_DECODE) begin
            class_reg <= dec_class;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      alu_op     = ALUOP_ADD;
      alu_src    = 1'b0;
      reg2loc    = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;

      case (state_reg)
         S_RESET: begin
            state_next = S_FETCH;
         end
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            // Decode uses the live classifier output; the register only loads at the edge
            if (dec_class == C_ILLEGAL) begin
               state_next = S_TRAP;
            end else if (dec_class == C_B) begin
               pc_write   = 1'b1;
               pc_src     = 1'b1;
               state_next = S_FETCH;
            end else begin
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_rtype(class_reg)) begin
               alu_op     = ALUOP_FUNCT;
               state_next = S_WB;
            end else if ((class_reg == C_LDUR) || (class_reg == C_STUR)) begin
               alu_src    = 1'b1;
               state_next = S_MEM;
            end else if (class_reg == C_CBZ) begin
               alu_op     = ALUOP_PASSB;
               reg2loc    = 1'b1;
               pc_write   = zero;
               pc_src     = 1'b1;
               state_next = S_FETCH;
            end else begin
               state_next = S_FETCH;
            end
         end
         S_MEM: begin
            i_or_d    = 1'b1;
            reg2loc   = 1'b1;
            mem_read  = (class_reg == C_LDUR);
            mem_write = (class_reg == C_STUR);
            if (mem_ready) begin
               state_next = (class_reg == C_LDUR) ? S_WB : S_FETCH;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = (class_reg == C_LDUR);
            state_next = S_FETCH;
         end
         S_TRAP: begin
            illegal = 1'b1;
         end
         default: begin
            state_next = S_RESET;
         end
      endcase
   end

   assign state_o = state_reg;

endmodule
